// File: rtl/state_poly_add_reduce.sv
// state_poly_add_reduce
// Streams INTT result words and matching noise/message (or v) words out of
// two synchronous-read buffers, combines them lane by lane modulo q and
// writes the reduced words to the result buffer at the originating address.
//   Encryption: out = (INTT + Err) mod q, words 0 .. 32*(KYBER_K+1)-1
//   Decryption: out = (v - INTT)   mod q, words 0 .. 31
module state_poly_add_reduce #(
  parameter int KYBER_K = 2,
  parameter int KYBER_Q = 3329,
  parameter int COEFF_W = 16,
  parameter int WORD_W  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mux_enc_dec,
  output logic [6:0]        INTT_Enc_BpV_DecMp_RAd,
  output logic              INTT_Enc_BpV_DecMp_Rd_en,
  input  logic [WORD_W-1:0] INTT_Enc_BpV_DecMp_RData,
  input  logic [WORD_W-1:0] Err_Msg_RData,
  output logic              Add_Enc_BpV_DecMp_outready,
  output logic [6:0]        Add_Enc_BpV_DecMp_WAd,
  output logic [WORD_W-1:0] Add_Enc_BpV_DecMp_WData,
  output logic              Function_done
);

  localparam int LANES = WORD_W / COEFF_W;

  // Last word address for each mode.
  localparam logic [6:0] ENC_LAST = 7'(32 * (KYBER_K + 1) - 1);
  localparam logic [6:0] DEC_LAST = 7'd31;

  // Modulus widened by one bit so sums and differences never overflow.
  localparam logic [COEFF_W:0] Q_W = (COEFF_W + 1)'(KYBER_Q);

  // FSM state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       mode_q,  mode_d;   // 1 = decryption, frozen for the whole run
  logic [6:0] rad_q,   rad_d;
  logic       rd_en_q, rd_en_d;
  logic       drain_q, drain_d;  // counts the two DRAIN cycles
  logic       done_q,  done_d;

  // Stage 1 tracks the read that the buffers are answering this cycle.
  logic       s1_valid_q;
  logic [6:0] s1_addr_q;

  logic              outready_q;
  logic [6:0]        wad_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] lane_res;
  logic [6:0]        last_addr;

  assign last_addr = mode_q ? DEC_LAST : ENC_LAST;

  // Control FSM: sequences addresses, drain and the done pulse.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    mode_d  = mode_q;
    rad_d   = rad_q;
    rd_en_d = rd_en_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_READ;
          mode_d  = mux_enc_dec;
          rad_d   = 7'd0;
          rd_en_d = 1'b1;
        end
      end
      S_READ: begin
        if (rad_q == last_addr) begin
          state_d = S_DRAIN;
          rad_d   = 7'd0;
          rd_en_d = 1'b0;
          drain_d = 1'b0;
        end else begin
          rad_d = rad_q + 7'd1;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_en_d = 1'b0;
        rad_d   = 7'd0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      rad_q   <= 7'd0;
      rd_en_q <= 1'b0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rad_q   <= rad_d;
      rd_en_q <= rd_en_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // Per-lane modular add (Enc) or subtract (Dec) of the returned words.
  always_comb begin
    logic [COEFF_W:0] a;
    logic [COEFF_W:0] b;
    logic [COEFF_W:0] s;
    logic [COEFF_W:0] r;
    lane_res = '0;
    a = '0;
    b = '0;
    s = '0;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      a = {1'b0, INTT_Enc_BpV_DecMp_RData[i*COEFF_W +: COEFF_W]};
      b = {1'b0, Err_Msg_RData[i*COEFF_W +: COEFF_W]};
      if (!mode_q) begin
        s = a + b;
        r = (s >= Q_W) ? s - Q_W : s;
      end else begin
        // The extra MSB acts as the sign of b - a.
        s = b - a;
        r = s[COEFF_W] ? s + Q_W : s;
      end
      lane_res[i*COEFF_W +: COEFF_W] = COEFF_W'(r);
    end
  end

  // Pipeline: follow each read through the buffer latency, then register the
  // reduced word together with its address; outputs rest at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= 7'd0;
      outready_q <= 1'b0;
      wad_q      <= 7'd0;
      wdata_q    <= '0;
    end else begin
      s1_valid_q <= rd_en_q;
      s1_addr_q  <= rad_q;
      outready_q <= s1_valid_q;
      wad_q      <= s1_valid_q ? s1_addr_q : 7'd0;
      wdata_q    <= s1_valid_q ? lane_res : '0;
    end
  end

  assign INTT_Enc_BpV_DecMp_RAd     = rad_q;
  assign INTT_Enc_BpV_DecMp_Rd_en   = rd_en_q;
  assign Add_Enc_BpV_DecMp_outready = outready_q;
  assign Add_Enc_BpV_DecMp_WAd      = wad_q;
  assign Add_Enc_BpV_DecMp_WData    = wdata_q;
  assign Function_done              = done_q;

endmodule
